// File: rtl/bench_pkg.sv
// Shared encodings for the benchmark monitor: FSM states, report word order, defaults.
package bench_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [1:0] RPT_CYC  = 2'd0;
  localparam logic [1:0] RPT_FLOW = 2'd1;
  localparam logic [1:0] RPT_RES  = 2'd2;
  localparam logic [1:0] RPT_PC   = 2'd3;

  localparam logic [31:0] DEFAULT_START_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_MAX_CYCLES = 32'h00FF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bench_pc_tracker.sv
// Tracks the previous PC, the run of identical PCs, and flags non-sequential
// transfers and the jump-to-self halt loop.
module bench_pc_tracker
  import bench_pkg::*;
#(
  parameter int HALT_REPEAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] addr,
  output logic        new_pc,
  output logic        nonseq,
  output logic        halt
);

  localparam logic [3:0] HALT_LAST = 4'(HALT_REPEAT - 1);

  logic [31:0] prev_addr;
  logic [3:0]  same_cnt;
  logic        same;

  assign same   = (addr == prev_addr);
  assign new_pc = !same;
  // +4 wraps modulo 2^32, so FFFFFFFC -> 00000000 is sequential
  assign nonseq = !same && (addr != prev_addr + 32'd4);
  assign halt   = advance && same && (same_cnt + 4'd1 == HALT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_addr <= '0;
      same_cnt  <= '0;
    end else if (load) begin
      prev_addr <= addr;
      same_cnt  <= '0;
    end else if (advance) begin
      prev_addr <= addr;
      same_cnt  <= same ? same_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: rtl/bench_monitor.sv
// Watches processor PC/result, detects start and halt loop, then streams a
// 4-word report (cycles, flow changes, result, final PC) over valid/ready.
module bench_monitor
  import bench_pkg::*;
#(
  parameter logic [31:0] START_PC    = DEFAULT_START_PC,
  parameter int          HALT_REPEAT = 4,
  parameter logic [31:0] MAX_CYCLES  = DEFAULT_MAX_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic        RPT_VALID,
  input  logic        RPT_READY,
  output logic [1:0]  RPT_IDX,
  output logic [31:0] RPT_DATA
);

  logic [1:0]  state;
  logic [31:0] cyc_cnt, flow_cnt, stamp;
  logic [31:0] res_q, pc_q, cyc_q;
  logic [1:0]  idx;
  logic        done_q, timeout_q;
  logic        load, advance, new_pc, nonseq, halt;
  logic [31:0] word;

  assign load    = (state == IDLE) && (ADDRESS == START_PC);
  assign advance = (state == RUN);

  bench_pc_tracker #(.HALT_REPEAT(HALT_REPEAT)) u_tracker (
    .clk     (CLK),
    .reset   (RESET),
    .load    (load),
    .advance (advance),
    .addr    (ADDRESS),
    .new_pc  (new_pc),
    .nonseq  (nonseq),
    .halt    (halt)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      flow_cnt  <= '0;
      stamp     <= '0;
      res_q     <= '0;
      pc_q      <= '0;
      cyc_q     <= '0;
      idx       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state    <= RUN;
            cyc_cnt  <= 32'd1;
            flow_cnt <= '0;
            stamp    <= 32'd1;
          end
        end
        RUN: begin
          cyc_cnt <= sat_inc(cyc_cnt);
          if (new_pc) stamp <= cyc_cnt + 32'd1;
          if (nonseq) flow_cnt <= flow_cnt + 32'd1;
          // halt takes priority over a coincident timeout
          if (halt) begin
            res_q  <= DATA;
            pc_q   <= ADDRESS;
            cyc_q  <= stamp;
            done_q <= 1'b1;
            idx    <= RPT_CYC;
            state  <= REPORT;
          end else if (cyc_cnt + 32'd1 == MAX_CYCLES) begin
            res_q     <= DATA;
            pc_q      <= ADDRESS;
            cyc_q     <= MAX_CYCLES;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            idx       <= RPT_CYC;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (RPT_READY) begin
            idx <= idx + 2'd1;
            if (idx == RPT_PC) state <= FINISH;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word = '0;
    case (idx)
      RPT_CYC:  word = cyc_q;
      RPT_FLOW: word = flow_cnt;
      RPT_RES:  word = res_q;
      default:  word = pc_q;
    endcase
  end

  assign BUSY      = (state == RUN);
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;
  assign RPT_VALID = (state == REPORT);
  assign RPT_IDX   = RPT_VALID ? idx : 2'd0;
  assign RPT_DATA  = RPT_VALID ? word : 32'd0;

endmodule

// File: tb/tb_bench_monitor.sv
// Directed scoreboard bench: expected report words are queued with the stimulus
// and popped by a monitor on every accepted handshake.
module tb_bench_monitor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADDRESS, DATA;
  logic        BUSY, DONE, TIMEOUT, RPT_VALID, RPT_READY;
  logic [1:0]  RPT_IDX;
  logic [31:0] RPT_DATA;

  typedef struct { logic [1:0] idx; logic [31:0] data; } word_t;
  word_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic        held_v = 1'b0;
  logic [1:0]  held_idx;
  logic [31:0] held_data;

  always #5 CLK = ~CLK;

  bench_monitor #(.START_PC(32'h3000), .HALT_REPEAT(4), .MAX_CYCLES(32'd16)) dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .DATA(DATA),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT),
    .RPT_VALID(RPT_VALID), .RPT_READY(RPT_READY),
    .RPT_IDX(RPT_IDX), .RPT_DATA(RPT_DATA)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] f, input logic [31:0] r, input logic [31:0] p);
    word_t w;
    w.idx = 2'd0; w.data = c; exp_q.push_back(w);
    w.idx = 2'd1; w.data = f; exp_q.push_back(w);
    w.idx = 2'd2; w.data = r; exp_q.push_back(w);
    w.idx = 2'd3; w.data = p; exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d);
    ADDRESS = a;
    DATA    = d;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b0; RPT_READY = 1'b0; ADDRESS = '0; DATA = '0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    {31'd0, BUSY},      32'd0);
    check({tag, "_done"},    {31'd0, DONE},      32'd0);
    check({tag, "_timeout"}, {31'd0, TIMEOUT},   32'd0);
    check({tag, "_valid"},   {31'd0, RPT_VALID}, 32'd0);
    check({tag, "_idx"},     {30'd0, RPT_IDX},   32'd0);
    check({tag, "_data"},    RPT_DATA,           32'd0);
  endtask

  // counts report-valid cycles with READY held high; bounded
  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (RPT_VALID) n++;
      else if (n > 0) break;
      tick();
    end
  endtask

  task automatic run_basic();
    step(32'h3000, 0); step(32'h3004, 0); step(32'h3008, 0);
    step(32'h3008, 0); step(32'h3008, 0); step(32'h3008, 32'h2A);
  endtask

  task automatic run_flow();
    step(32'h3000, 0); step(32'h3004, 0); step(32'h3010, 0); step(32'h3014, 0);
    step(32'h300C, 0); step(32'h300C, 0); step(32'h300C, 0); step(32'h300C, 32'h55);
  endtask

  always @(negedge CLK) begin
    word_t w;
    if (held_v && RPT_VALID) begin
      check("hold_idx", {30'd0, RPT_IDX}, {30'd0, held_idx});
      check("hold_data", RPT_DATA, held_data);
    end
    held_v    = RPT_VALID && !RPT_READY;
    held_idx  = RPT_IDX;
    held_data = RPT_DATA;
    if (RPT_VALID && RPT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word idx=%0d data=%h", RPT_IDX, RPT_DATA);
      end else begin
        w = exp_q.pop_front();
        check("rpt_idx", {30'd0, RPT_IDX}, {30'd0, w.idx});
        check("rpt_data", RPT_DATA, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1'b0; ADDRESS = '0; DATA = '0; RPT_READY = 1'b0;
    tick(); tick();
    check_zero("reset");
    RESET = 1'b1;

    // basic run, READY always high
    RPT_READY = 1'b1;
    push(32'd3, 32'd0, 32'h2A, 32'h3008);
    run_basic();
    check("basic_done", {31'd0, DONE}, 32'd1);
    drain(n);
    check("basic_valid_cycles", n, 32'd4);
    check("basic_timeout", {31'd0, TIMEOUT}, 32'd0);
    check("basic_busy_finish", {31'd0, BUSY}, 32'd0);
    check("basic_q_empty", exp_q.size(), 32'd0);

    // flow count with backpressure before every word
    do_reset();
    push(32'd5, 32'd2, 32'h55, 32'h300C);
    run_flow();
    check("bp_valid", {31'd0, RPT_VALID}, 32'd1);
    for (int w = 0; w < 4; w++) begin
      RPT_READY = 1'b0;
      repeat (3) tick();
      RPT_READY = 1'b1;
      tick();
    end
    RPT_READY = 1'b0;
    check("bp_finish_valid", {31'd0, RPT_VALID}, 32'd0);
    check("bp_done", {31'd0, DONE}, 32'd1);
    check("bp_q_empty", exp_q.size(), 32'd0);

    // timeout: PC increments forever, MAX_CYCLES = 16
    do_reset();
    RPT_READY = 1'b1;
    push(32'd16, 32'd0, 32'h10F, 32'h303C);
    for (int i = 0; i < 16; i++) step(32'h3000 + 32'(4 * i), 32'h100 + 32'(i));
    check("to_timeout", {31'd0, TIMEOUT}, 32'd1);
    check("to_done", {31'd0, DONE}, 32'd1);
    drain(n);
    check("to_valid_cycles", n, 32'd4);
    check("to_timeout_held", {31'd0, TIMEOUT}, 32'd1);
    check("to_q_empty", exp_q.size(), 32'd0);

    // pre-start samples ignored, then wrap FFFFFFFC -> 0 is sequential
    do_reset();
    RPT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(32'h2FFC, 0);
      check("pre_busy", {31'd0, BUSY}, 32'd0);
    end
    push(32'd3, 32'd1, 32'h77, 32'h0);
    step(32'h3000, 0);
    check("start_busy", {31'd0, BUSY}, 32'd1);
    step(32'hFFFF_FFFC, 0);
    step(32'h0, 0); step(32'h0, 0); step(32'h0, 0); step(32'h0, 32'h77);
    drain(n);
    check("wrap_valid_cycles", n, 32'd4);
    check("wrap_q_empty", exp_q.size(), 32'd0);

    // reset while word 2 is presented, then a fresh run
    do_reset();
    exp_q.push_back('{idx: 2'd0, data: 32'd3});
    exp_q.push_back('{idx: 2'd1, data: 32'd0});
    run_basic();
    RPT_READY = 1'b1;
    tick(); tick();
    RPT_READY = 1'b0;
    check("mid_idx", {30'd0, RPT_IDX}, 32'd2);
    RESET = 1'b0;
    tick();
    check_zero("mid_reset");
    RESET = 1'b1;
    check("mid_q_empty", exp_q.size(), 32'd0);
    RPT_READY = 1'b1;
    push(32'd5, 32'd2, 32'h55, 32'h300C);
    run_flow();
    drain(n);
    check("fresh_valid_cycles", n, 32'd4);
    check("fresh_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
